alu_sched: RTL and testbench

Two-requester scheduler in front of the shared combinational ALU. It arbitrates round-robin between two valid/ready request ports and holds the ALU operands stable for the op's latency: 1 cycle for ADD/SUB, MUL_LAT cycles for MUL as a multicycle path. It returns each result on a single valid/ready response port tagged with the requester id. Sits between the decode/issue logic and the ALU instance, which it drives through alu_op/alu_x/alu_y and reads back through alu_w.

---
 rtl/alu_sched.sv | 202 ++++++++++++++++++++
 tb/tb_alu_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler for two requesters sharing one combinational ALU.
// Define ALU_SCHED_MUL_EN to run MUL as a MUL_LAT-cycle multicycle path; otherwise MUL is illegal.

`ifndef ADD
`define ADD 7'h01
`endif
`ifndef SUB
`define SUB 7'h02
`endif
`ifndef MUL
`define MUL 7'h03
`endif
`ifndef LDW
`define LDW 7'h10
`endif
`ifndef ALU_X
`define ALU_X 32'hDEAD_BEEF
`endif

module alu_sched #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [6:0]  req0_op,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [6:0]  req1_op,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    output logic [6:0]  alu_op,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_w,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_illegal
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("alu_sched: MUL_LAT must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic        last_grant_q, last_grant_d;
    logic        illegal_q, illegal_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    logic        grant;
    logic        sel_valid;
    logic [6:0]  sel_op;
    logic [31:0] sel_x;
    logic [31:0] sel_y;
    logic        sel_illegal;
    logic        accept;
    logic        exec_done;

`ifdef ALU_SCHED_MUL_EN
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_mul;
`endif

    // Tie goes to whoever did not win last; a lone valid requester always wins.
    always_comb begin
        grant     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        sel_valid = grant ? req1_valid : req0_valid;
        sel_op    = grant ? req1_op : req0_op;
        sel_x     = grant ? req1_x : req0_x;
        sel_y     = grant ? req1_y : req0_y;
        accept    = (state_q == StIdle) && rst_n && sel_valid;
    end

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_comb begin
        sel_illegal = 1'b1;
`ifdef ALU_SCHED_MUL_EN
        sel_mul     = 1'b0;
`endif
        case (sel_op)
            `ADD, `SUB: sel_illegal = 1'b0;
`ifdef ALU_SCHED_MUL_EN
            `MUL: begin
                sel_illegal = 1'b0;
                sel_mul     = 1'b1;
            end
`endif
            default: sel_illegal = 1'b1;
        endcase
    end

`ifdef ALU_SCHED_MUL_EN
    assign exec_done = (cnt_q == 4'd0);
`else
    assign exec_done = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        x_d           = x_q;
        y_d           = y_q;
        last_grant_d  = last_grant_q;
        illegal_d     = illegal_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_illegal_d = rsp_illegal_q;
`ifdef ALU_SCHED_MUL_EN
        cnt_d         = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // Illegal ops never reach the ALU, so its inputs do not toggle for them.
                    if (!sel_illegal) begin
                        op_d = sel_op;
                        x_d  = sel_x;
                        y_d  = sel_y;
                    end
                    illegal_d    = sel_illegal;
                    rsp_id_d     = grant;
                    last_grant_d = grant;
`ifdef ALU_SCHED_MUL_EN
                    cnt_d        = sel_mul ? 4'(MUL_LAT - 1) : 4'd0;
`endif
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (exec_done) begin
                    rsp_data_d    = illegal_q ? `ALU_X : alu_w;
                    rsp_illegal_d = illegal_q;
                    state_d       = StResp;
                end
`ifdef ALU_SCHED_MUL_EN
                else begin
                    cnt_d = cnt_q - 4'd1;
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_q          <= 7'd0;
            x_q           <= 32'd0;
            y_q           <= 32'd0;
            last_grant_q  <= 1'b1;
            illegal_q     <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_illegal_q <= 1'b0;
`ifdef ALU_SCHED_MUL_EN
            cnt_q         <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            x_q           <= x_d;
            y_q           <= y_d;
            last_grant_q  <= last_grant_d;
            illegal_q     <= illegal_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_illegal_q <= rsp_illegal_d;
`ifdef ALU_SCHED_MUL_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign alu_op      = op_q;
    assign alu_x       = x_q;
    assign alu_y       = y_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed scenarios plus randomised traffic against a
// transaction-level model that predicts grants, response timing and results.
`timescale 1ns/1ps

`ifndef ADD
`define ADD 7'h01
`endif
`ifndef SUB
`define SUB 7'h02
`endif
`ifndef MUL
`define MUL 7'h03
`endif
`ifndef LDW
`define LDW 7'h10
`endif
`ifndef ALU_X
`define ALU_X 32'hDEAD_BEEF
`endif

module tb_alu_sched;

    localparam int unsigned MulLat = 3;
`ifdef ALU_SCHED_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0]  req0_op, req1_op;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic [6:0]  alu_op;
    logic [31:0] alu_x, alu_y, alu_w;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_illegal;
    logic [31:0] rsp_data;

    alu_sched #(.MUL_LAT(MulLat)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .alu_op     (alu_op),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_w      (alu_w),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_illegal(rsp_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared ALU stand-in; unknown opcodes give a value unlike ALU_X.
    always_comb begin
        case (alu_op)
            `ADD:    alu_w = alu_x + alu_y;
            `SUB:    alu_w = alu_x - alu_y;
            `MUL:    alu_w = alu_x * alu_y;
            default: alu_w = alu_x ^ ~alu_y;
        endcase
    end

    int unsigned n_pass;
    int unsigned n_total;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: one pending transaction with a due cycle for its response.
    int          m_cyc;
    bit          m_busy;
    int          m_due;
    bit          m_last;
    bit          m_fresh;
    bit          m_id;
    bit          m_ill;
    logic [31:0] m_data;
    logic [6:0]  v_op;
    logic [31:0] v_x, v_y;
    bit          acc0, acc1;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_last  = 1'b1;
        m_fresh = 1'b1;
        v_op    = 7'd0;
        v_x     = 32'd0;
        v_y     = 32'd0;
    endtask

    task automatic model_accept(input bit id, input logic [6:0] op, input logic [31:0] x,
                                input logic [31:0] y);
        logic [63:0] prod;
        bit          legal;
        int          lat;
        prod  = 64'(x) * 64'(y);
        legal = (op == `ADD) || (op == `SUB) || (MulEn && op == `MUL);
        lat   = (MulEn && op == `MUL) ? int'(MulLat) : 1;
        if (op == `ADD) m_data = x + y;
        else if (op == `SUB) m_data = x - y;
        else if (legal) m_data = prod[31:0];
        else m_data = `ALU_X;
        m_ill  = !legal;
        m_id   = id;
        m_last = id;
        m_busy = 1'b1;
        m_due  = m_cyc + lat + 1;
        if (legal) begin
            v_op = op;
            v_x  = x;
            v_y  = y;
        end
    endtask

    task automatic model_step();
        bit e0, e1;
        m_cyc++;
        acc0 = 1'b0;
        acc1 = 1'b0;
        check_eq("alu_op", 32'(alu_op), 32'(v_op));
        check_eq("alu_x", alu_x, v_x);
        check_eq("alu_y", alu_y, v_y);
        if (!rst_n) begin
            check_eq("ready0_in_reset", 32'(req0_ready), 32'd0);
            check_eq("ready1_in_reset", 32'(req1_ready), 32'd0);
            model_reset();
            return;
        end
        if (m_fresh) begin
            check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("reset_rsp_id", 32'(rsp_id), 32'd0);
            check_eq("reset_rsp_data", rsp_data, 32'd0);
            check_eq("reset_rsp_illegal", 32'(rsp_illegal), 32'd0);
            m_fresh = 1'b0;
        end
        if (m_busy) begin
            check_eq("ready0_busy", 32'(req0_ready), 32'd0);
            check_eq("ready1_busy", 32'(req1_ready), 32'd0);
            check_eq("rsp_valid", 32'(rsp_valid), 32'(m_cyc >= m_due));
            if (m_cyc >= m_due) begin
                check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
                check_eq("rsp_data", rsp_data, m_data);
                check_eq("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
                if (rsp_ready) m_busy = 1'b0;
            end
        end else begin
            // Requester 0 wins unless requester 1 also asks and 0 had the last turn.
            e0 = req0_valid && (!req1_valid || m_last);
            e1 = req1_valid && !e0;
            check_eq("req0_ready", 32'(req0_ready), 32'(e0));
            check_eq("req1_ready", 32'(req1_ready), 32'(e1));
            check_eq("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            if (e0) begin
                acc0 = 1'b1;
                model_accept(1'b0, req0_op, req0_x, req0_y);
            end else if (e1) begin
                acc1 = 1'b1;
                model_accept(1'b1, req1_op, req1_x, req1_y);
            end
        end
    endtask

    task automatic cyc(input logic v0, input logic [6:0] o0, input logic [31:0] x0,
                       input logic [31:0] y0, input logic v1, input logic [6:0] o1,
                       input logic [31:0] x1, input logic [31:0] y1, input logic rr,
                       input logic rn);
        @(posedge clk);
        #1;
        req0_valid = v0;
        req0_op    = o0;
        req0_x     = x0;
        req0_y     = y0;
        req1_valid = v1;
        req1_op    = o1;
        req1_x     = x1;
        req1_y     = y1;
        rsp_ready  = rr;
        rst_n      = rn;
        #2;
        model_step();
    endtask

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return `ADD;
            1:       return `SUB;
            2:       return `MUL;
            3:       return `LDW;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0001_0000;
            default: return $urandom;
        endcase
    endfunction

    bit          p_v[2];
    logic [6:0]  p_op[2];
    logic [31:0] p_x[2];
    logic [31:0] p_y[2];

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_cyc   = 0;
        model_reset();
        acc0 = 1'b0;
        acc1 = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_op = 7'd0;
        req1_op = 7'd0;
        req0_x = 32'd0;
        req0_y = 32'd0;
        req1_x = 32'd0;
        req1_y = 32'd0;
        rsp_ready = 1'b0;

        // Reset with both requesters asking: nothing may be accepted.
        cyc(1, `ADD, 1, 2, 1, `ADD, 3, 4, 1, 0);
        cyc(1, `ADD, 1, 2, 1, `ADD, 3, 4, 1, 0);
        cyc(0, `ADD, 0, 0, 0, `ADD, 0, 0, 1, 1);

        // ADD 7+5 from requester 0.
        cyc(1, `ADD, 7, 5, 0, `ADD, 0, 0, 1, 1);
        repeat (3) cyc(0, `ADD, 0, 0, 0, `ADD, 0, 0, 1, 1);

        // SUB 0-1 from requester 1 with a stalled consumer; both keep asking meanwhile.
        cyc(0, `ADD, 0, 0, 1, `SUB, 0, 1, 0, 1);
        repeat (5) cyc(1, `ADD, 9, 9, 1, `ADD, 8, 8, 0, 1);
        cyc(1, `ADD, 9, 9, 1, `ADD, 8, 8, 1, 1);

        // Both valid every cycle: grants alternate.
        repeat (14) cyc(1, `ADD, 32'h11, 32'h22, 1, `ADD, 32'h33, 32'h44, 1, 1);
        repeat (3) cyc(0, `ADD, 0, 0, 0, `ADD, 0, 0, 1, 1);

        // MUL with a wrapping product.
        cyc(1, `MUL, 32'h1_0000, 32'h1_0000, 0, `ADD, 0, 0, 1, 1);
        repeat (6) cyc(0, `ADD, 0, 0, 0, `ADD, 0, 0, 1, 1);

        // Illegal opcode leaves the ALU inputs alone.
        cyc(1, `LDW, 32'h55, 32'h66, 0, `ADD, 0, 0, 1, 1);
        repeat (4) cyc(0, `ADD, 0, 0, 0, `ADD, 0, 0, 1, 1);

        // Reset during the second execute cycle of a MUL, then a tie.
        cyc(1, `MUL, 32'h123, 32'h456, 0, `ADD, 0, 0, 1, 1);
        cyc(0, `ADD, 0, 0, 0, `ADD, 0, 0, 1, 1);
        cyc(1, `ADD, 5, 6, 1, `SUB, 7, 8, 1, 0);
        cyc(1, `ADD, 5, 6, 1, `SUB, 7, 8, 1, 1);
        repeat (4) cyc(0, `ADD, 0, 0, 0, `ADD, 0, 0, 1, 1);

        // Randomised traffic; requests hold until accepted.
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i] && $urandom_range(0, 99) < 50) begin
                    p_v[i]  = 1'b1;
                    p_op[i] = rand_op();
                    p_x[i]  = rand_opnd();
                    p_y[i]  = rand_opnd();
                end
            end
            cyc(p_v[0], p_op[0], p_x[0], p_y[0], p_v[1], p_op[1], p_x[1], p_y[1],
                logic'($urandom_range(0, 99) < 70), logic'($urandom_range(0, 199) != 0));
            if (acc0) p_v[0] = 1'b0;
            if (acc1) p_v[1] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
